// File: rtl/alu_regfile_core.sv
// alu_regfile_core: register file plus 16-op ALU behind a valid/ready command port.
// A command is accepted only in IDLE. Single-cycle ops pass through EXEC and the
// multiply through MUL, one shift-add step per cycle. The result is written and the
// flags are updated on the edge that leaves EXEC/MUL, and rsp_valid pulses for one
// cycle in DONE.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_op                opcode
//   cmd_wr_adrs           destination register
//   cmd_rd_a, cmd_rd_b    source registers
//   cmd_data              LOAD immediate
//   rsp_valid             one-cycle completion pulse
//   rsp_result            last completed result, held between completions
//   flag_zero/carry/neg/ovf  registered status flags
//   dbg_adrs, dbg_data    combinational register-file read port
module alu_regfile_core #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_wr_adrs,
    input  logic [ADDR_W-1:0] cmd_rd_a,
    input  logic [ADDR_W-1:0] cmd_rd_b,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_result,
    output logic              flag_zero,
    output logic              flag_carry,
    output logic              flag_neg,
    output logic              flag_ovf,
    input  logic [ADDR_W-1:0] dbg_adrs,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int unsigned NREG  = 2 ** ADDR_W;
    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam int unsigned MSB   = DATA_W - 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SHL  = 4'd2;
    localparam logic [3:0] OP_ROR  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_ADC  = 4'd8;
    localparam logic [3:0] OP_SBC  = 4'd9;
    localparam logic [3:0] OP_SHR  = 4'd10;
    localparam logic [3:0] OP_ROL  = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;
    localparam logic [3:0] OP_LOAD = 4'd13;
    localparam logic [3:0] OP_MOV  = 4'd14;
    localparam logic [3:0] OP_CMP  = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   regs [NREG];
    logic [3:0]          op_q;
    logic [ADDR_W-1:0]   wr_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   imm_q;

    // Shift-add multiplier: accumulator, left-shifting multiplicand, right-shifting multiplier
    logic [2*DATA_W-1:0] mul_acc;
    logic [2*DATA_W-1:0] mul_mcand;
    logic [DATA_W-1:0]   mul_mplier;
    logic [CNT_W-1:0]    mul_cnt;
    logic [2*DATA_W-1:0] mul_prod_c;

    logic [DATA_W:0]     ext_c;
    logic [DATA_W-1:0]   alu_res_c;
    logic                alu_carry_c;
    logic                alu_ovf_c;
    logic                upd_flags_c;
    logic                wr_en_c;
    logic                commit_c;

    assign dbg_data = regs[dbg_adrs];

    // Accumulator value after the current partial product is added
    assign mul_prod_c = mul_acc + (mul_mplier[0] ? mul_mcand : (2*DATA_W)'(0));

    // Commit on the last cycle of EXEC or MUL
    assign commit_c = (state == S_EXEC) ||
                      ((state == S_MUL) && (mul_cnt == CNT_W'(DATA_W - 1)));

    // ALU result and flag candidates for the latched command
    always_comb begin
        ext_c       = '0;
        alu_res_c   = '0;
        alu_carry_c = flag_carry;
        alu_ovf_c   = flag_ovf;
        upd_flags_c = 1'b1;
        wr_en_c     = 1'b1;
        case (op_q)
            OP_ADD, OP_ADC: begin
                ext_c = {1'b0, a_q} + {1'b0, b_q} +
                        (DATA_W+1)'((op_q == OP_ADC) ? flag_carry : 1'b0);
                alu_res_c   = ext_c[DATA_W-1:0];
                alu_carry_c = ext_c[DATA_W];
                alu_ovf_c   = (a_q[MSB] == b_q[MSB]) && (alu_res_c[MSB] != a_q[MSB]);
            end
            OP_SUB, OP_SBC, OP_CMP: begin
                // Bit DATA_W of the extended difference is the borrow
                ext_c = {1'b0, a_q} - {1'b0, b_q} -
                        (DATA_W+1)'((op_q == OP_SBC) ? flag_carry : 1'b0);
                alu_res_c   = ext_c[DATA_W-1:0];
                alu_carry_c = ext_c[DATA_W];
                alu_ovf_c   = (a_q[MSB] != b_q[MSB]) && (alu_res_c[MSB] != a_q[MSB]);
                wr_en_c     = (op_q != OP_CMP);
            end
            OP_SHL: begin
                alu_res_c   = {a_q[DATA_W-2:0], 1'b0};
                alu_carry_c = a_q[MSB];
                alu_ovf_c   = 1'b0;
            end
            OP_SHR: begin
                alu_res_c   = {1'b0, a_q[DATA_W-1:1]};
                alu_carry_c = a_q[0];
                alu_ovf_c   = 1'b0;
            end
            OP_ROR: begin
                alu_res_c   = {a_q[0], a_q[DATA_W-1:1]};
                alu_carry_c = a_q[0];
                alu_ovf_c   = 1'b0;
            end
            OP_ROL: begin
                alu_res_c   = {a_q[DATA_W-2:0], a_q[MSB]};
                alu_carry_c = a_q[MSB];
                alu_ovf_c   = 1'b0;
            end
            OP_AND: begin
                alu_res_c   = a_q & b_q;
                alu_carry_c = 1'b0;
                alu_ovf_c   = 1'b0;
            end
            OP_OR: begin
                alu_res_c   = a_q | b_q;
                alu_carry_c = 1'b0;
                alu_ovf_c   = 1'b0;
            end
            OP_XOR: begin
                alu_res_c   = a_q ^ b_q;
                alu_carry_c = 1'b0;
                alu_ovf_c   = 1'b0;
            end
            OP_NOT: begin
                alu_res_c   = ~a_q;
                alu_carry_c = 1'b0;
                alu_ovf_c   = 1'b0;
            end
            OP_MUL: begin
                alu_res_c   = mul_prod_c[DATA_W-1:0];
                alu_carry_c = |mul_prod_c[2*DATA_W-1:DATA_W];
                alu_ovf_c   = 1'b0;
            end
            OP_LOAD: begin
                alu_res_c   = imm_q;
                upd_flags_c = 1'b0;
            end
            OP_MOV: begin
                alu_res_c   = a_q;
                upd_flags_c = 1'b0;
            end
        endcase
    end

    // Control FSM, operand latches, multiplier, register file and outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            flag_neg   <= 1'b0;
            flag_ovf   <= 1'b0;
            op_q       <= '0;
            wr_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            imm_q      <= '0;
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_cnt    <= '0;
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q       <= cmd_op;
                        wr_q       <= cmd_wr_adrs;
                        a_q        <= regs[cmd_rd_a];
                        b_q        <= regs[cmd_rd_b];
                        imm_q      <= cmd_data;
                        mul_acc    <= '0;
                        mul_mcand  <= {DATA_W'(0), regs[cmd_rd_a]};
                        mul_mplier <= regs[cmd_rd_b];
                        mul_cnt    <= '0;
                        cmd_ready  <= 1'b0;
                        state      <= (cmd_op == OP_MUL) ? S_MUL : S_EXEC;
                    end
                end
                S_EXEC: begin
                    state <= S_DONE;
                end
                S_MUL: begin
                    mul_acc    <= mul_prod_c;
                    mul_mcand  <= {mul_mcand[2*DATA_W-2:0], 1'b0};
                    mul_mplier <= {1'b0, mul_mplier[DATA_W-1:1]};
                    mul_cnt    <= mul_cnt + CNT_W'(1);
                    if (commit_c) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase

            if (commit_c) begin
                rsp_valid  <= 1'b1;
                rsp_result <= alu_res_c;
                if (wr_en_c) begin
                    regs[wr_q] <= alu_res_c;
                end
                if (upd_flags_c) begin
                    flag_zero  <= (alu_res_c == '0);
                    flag_carry <= alu_carry_c;
                    flag_neg   <= alu_res_c[MSB];
                    flag_ovf   <= alu_ovf_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_regfile_core.sv
// Scoreboard bench for alu_regfile_core: an 8-bit/8-register instance and a
// 16-bit/16-register instance share clock and reset. Each accepted command pushes
// its hand-computed result, flags {zero,carry,neg,ovf} and latency. A monitor per
// instance pops and compares on every rsp_valid.
module tb_alu_regfile_core;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SHL  = 4'd2;
    localparam logic [3:0] OP_ROR  = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_ADC  = 4'd8;
    localparam logic [3:0] OP_SBC  = 4'd9;
    localparam logic [3:0] OP_SHR  = 4'd10;
    localparam logic [3:0] OP_ROL  = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;
    localparam logic [3:0] OP_LOAD = 4'd13;
    localparam logic [3:0] OP_MOV  = 4'd14;
    localparam logic [3:0] OP_CMP  = 4'd15;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flg;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        v8, r8, rv8, z8, c8, n8, o8;
    logic [3:0]  op8;
    logic [2:0]  wa8, ra8, rb8, da8;
    logic [7:0]  d8, res8, dd8;

    logic        v16, r16, rv16, z16, c16, n16, o16;
    logic [3:0]  op16;
    logic [3:0]  wa16, ra16, rb16, da16;
    logic [15:0] d16, res16, dd16;

    alu_regfile_core #(.DATA_W(8), .ADDR_W(3)) u8 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(v8), .cmd_ready(r8), .cmd_op(op8),
        .cmd_wr_adrs(wa8), .cmd_rd_a(ra8), .cmd_rd_b(rb8), .cmd_data(d8),
        .rsp_valid(rv8), .rsp_result(res8), .flag_zero(z8), .flag_carry(c8),
        .flag_neg(n8), .flag_ovf(o8), .dbg_adrs(da8), .dbg_data(dd8));

    alu_regfile_core #(.DATA_W(16), .ADDR_W(4)) u16 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(v16), .cmd_ready(r16), .cmd_op(op16),
        .cmd_wr_adrs(wa16), .cmd_rd_a(ra16), .cmd_rd_b(rb16), .cmd_data(d16),
        .rsp_valid(rv16), .rsp_result(res16), .flag_zero(z16), .flag_carry(c16),
        .flag_neg(n16), .flag_ovf(o16), .dbg_adrs(da16), .dbg_data(dd16));

    exp_t q8[$];
    exp_t q16[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic pv8 = 1'b0;
    logic pv16 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor for the 8-bit instance
    always @(negedge clk) begin
        exp_t e;
        if (rv8 === 1'b1) begin
            check("rsp8_single_cycle", 32'(pv8), 32'(0));
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL rsp8_unexpected actual=%0h expected=none", res8);
            end else begin
                e = q8.pop_front();
                check("rsp8_result", 32'(res8), 32'(e.res));
                check("rsp8_flags_zcnv", 32'({z8, c8, n8, o8}), 32'(e.flg));
                check("rsp8_latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
        pv8 = rv8;
    end

    // Monitor for the 16-bit instance
    always @(negedge clk) begin
        exp_t e;
        if (rv16 === 1'b1) begin
            check("rsp16_single_cycle", 32'(pv16), 32'(0));
            checks++;
            if (q16.size() == 0) begin
                errors++;
                $display("FAIL rsp16_unexpected actual=%0h expected=none", res16);
            end else begin
                e = q16.pop_front();
                check("rsp16_result", 32'(res16), 32'(e.res));
                check("rsp16_flags_zcnv", 32'({z16, c16, n16, o16}), 32'(e.flg));
                check("rsp16_latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
        pv16 = rv16;
    end

    // Wait (at negedges) until the selected instance is ready, bounded
    task automatic wait_ready(input bit w);
        int n = 0;
        while (((w ? r16 : r8) !== 1'b1) && (n < 60)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL ready_timeout actual=0 expected=1 (wide=%0d)", w);
        end
    endtask

    // Issue one command; push its expectation once it is accepted
    task automatic send(input bit w, input logic [3:0] op, input int wa, input int ra,
                        input int rb, input logic [15:0] data, input logic [15:0] eres,
                        input logic [3:0] eflg, input bit expect_rsp);
        exp_t e;
        @(negedge clk);
        wait_ready(w);
        if (w) begin
            op16 = op; wa16 = 4'(wa); ra16 = 4'(ra); rb16 = 4'(rb); d16 = data; v16 = 1'b1;
        end else begin
            op8 = op; wa8 = 3'(wa); ra8 = 3'(ra); rb8 = 3'(rb); d8 = data[7:0]; v8 = 1'b1;
        end
        @(posedge clk);
        #1;
        if (expect_rsp) begin
            e.res = eres;
            e.flg = eflg;
            e.lat = (op == OP_MUL) ? (w ? 16 : 8) : 1;
            e.acc = cyc;
            if (w) q16.push_back(e);
            else   q8.push_back(e);
        end
        @(negedge clk);
        if (w) v16 = 1'b0;
        else   v8 = 1'b0;
    endtask

    task automatic dbg8(input string name, input int adr, input logic [7:0] exp);
        da8 = 3'(adr);
        #1;
        check(name, 32'(dd8), 32'(exp));
    endtask

    task automatic dbg16(input string name, input int adr, input logic [15:0] exp);
        da16 = 4'(adr);
        #1;
        check(name, 32'(dd16), 32'(exp));
    endtask

    initial begin
        // Reset with a command pending: it must be dropped
        rst_n = 1'b0;
        v8 = 1'b1; op8 = OP_LOAD; wa8 = 3'd1; ra8 = '0; rb8 = '0; d8 = 8'hAA; da8 = '0;
        v16 = 1'b1; op16 = OP_LOAD; wa16 = 4'd1; ra16 = '0; rb16 = '0; d16 = 16'hAAAA; da16 = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        v8 = 1'b0;
        v16 = 1'b0;
        check("rst_ready8", 32'(r8), 32'(1));
        check("rst_rsp_valid8", 32'(rv8), 32'(0));
        check("rst_flags8", 32'({z8, c8, n8, o8}), 32'(0));
        check("rst_result8", 32'(res8), 32'(0));
        for (int i = 0; i < 8; i++) dbg8("rst_reg8", i, 8'h00);

        // Add with carry-out, then add-with-carry consuming it
        send(0, OP_LOAD, 1, 0, 0, 16'hF0, 16'hF0, 4'b0000, 1);
        send(0, OP_LOAD, 2, 0, 0, 16'h20, 16'h20, 4'b0000, 1);
        send(0, OP_ADD,  3, 1, 2, 16'h00, 16'h10, 4'b0100, 1);
        send(0, OP_ADC,  4, 0, 0, 16'h00, 16'h01, 4'b0000, 1);
        wait_ready(0);
        dbg8("add_r3", 3, 8'h10);
        dbg8("adc_r4", 4, 8'h01);

        // Signed overflow on subtract; compare does not write
        send(0, OP_LOAD, 1, 0, 0, 16'h80, 16'h80, 4'b0000, 1);
        send(0, OP_LOAD, 2, 0, 0, 16'h01, 16'h01, 4'b0000, 1);
        send(0, OP_SUB,  3, 1, 2, 16'h00, 16'h7F, 4'b0001, 1);
        send(0, OP_CMP,  5, 1, 1, 16'h00, 16'h00, 4'b1000, 1);
        wait_ready(0);
        dbg8("sub_r3", 3, 8'h7F);
        dbg8("cmp_no_write_r5", 5, 8'h00);
        dbg8("cmp_keeps_r1", 1, 8'h80);

        // Shifts, rotates and NOT on 0x81
        send(0, OP_LOAD, 1, 0, 0, 16'h81, 16'h81, 4'b1000, 1);
        send(0, OP_SHL,  2, 1, 0, 16'h00, 16'h02, 4'b0100, 1);
        send(0, OP_SHR,  3, 1, 0, 16'h00, 16'h40, 4'b0100, 1);
        send(0, OP_ROR,  4, 1, 0, 16'h00, 16'hC0, 4'b0110, 1);
        send(0, OP_ROL,  5, 1, 0, 16'h00, 16'h03, 4'b0100, 1);
        send(0, OP_NOT,  6, 1, 0, 16'h00, 16'h7E, 4'b0000, 1);
        wait_ready(0);
        dbg8("shl_r2", 2, 8'h02);
        dbg8("shr_r3", 3, 8'h40);
        dbg8("ror_r4", 4, 8'hC0);
        dbg8("rol_r5", 5, 8'h03);
        dbg8("not_r6", 6, 8'h7E);

        // Multiplies; second one with a competing command held on the port
        send(0, OP_LOAD, 1, 0, 0, 16'h0F, 16'h0F, 4'b0000, 1);
        send(0, OP_LOAD, 2, 0, 0, 16'h11, 16'h11, 4'b0000, 1);
        send(0, OP_MUL,  3, 1, 2, 16'h00, 16'hFF, 4'b0010, 1);
        send(0, OP_LOAD, 1, 0, 0, 16'h10, 16'h10, 4'b0010, 1);
        send(0, OP_MUL,  4, 1, 1, 16'h00, 16'h00, 4'b1100, 1);
        v8 = 1'b1; op8 = OP_ADD; wa8 = 3'd7; ra8 = 3'd1; rb8 = 3'd1;
        for (int i = 0; i < 8; i++) begin
            check("busy_ready_low", 32'(r8), 32'(0));
            @(negedge clk);
        end
        v8 = 1'b0;
        wait_ready(0);
        dbg8("mul_r3", 3, 8'hFF);
        dbg8("mul_r4", 4, 8'h00);
        dbg8("busy_no_write_r7", 7, 8'h00);

        // Subtract-with-borrow uses carry=1 left by the multiply; MOV keeps flags
        send(0, OP_SBC, 6, 4, 0, 16'h00, 16'hFF, 4'b0110, 1);
        send(0, OP_MOV, 7, 3, 0, 16'h00, 16'hFF, 4'b0110, 1);
        wait_ready(0);
        dbg8("sbc_r6", 6, 8'hFF);
        dbg8("mov_r7", 7, 8'hFF);

        // Reset in the middle of a multiply aborts it
        send(0, OP_LOAD, 1, 0, 0, 16'h03, 16'h03, 4'b0110, 1);
        send(0, OP_MUL,  2, 1, 1, 16'h00, 16'h00, 4'b0000, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_ready", 32'(r8), 32'(1));
        check("abort_flags", 32'({z8, c8, n8, o8}), 32'(0));
        dbg8("abort_r1", 1, 8'h00);
        repeat (12) @(negedge clk);
        dbg8("abort_r2", 2, 8'h00);
        check("abort_rsp_result", 32'(res8), 32'(0));

        // Wide instance: carry out of the top bit, top register, 16-cycle multiply
        send(1, OP_LOAD, 15, 0, 0, 16'hFFFF, 16'hFFFF, 4'b0000, 1);
        send(1, OP_LOAD, 0, 0, 0, 16'h0001, 16'h0001, 4'b0000, 1);
        send(1, OP_ADD, 14, 15, 0, 16'h0000, 16'h0000, 4'b1100, 1);
        send(1, OP_MUL, 13, 15, 15, 16'h0000, 16'h0001, 4'b0100, 1);
        wait_ready(1);
        dbg16("w_r15", 15, 16'hFFFF);
        dbg16("w_r14", 14, 16'h0000);
        dbg16("w_r13", 13, 16'h0001);

        repeat (3) @(negedge clk);
        check("q8_drained", 32'(q8.size()), 32'(0));
        check("q16_drained", 32'(q16.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
